// File: rtl/commit_arbiter.sv
// commit_arbiter: per-unit result queues merged round-robin onto registered regfile write ports.
// Define COMMIT_BYPASS_EN to let an empty queue's live result be granted in its presentation cycle.
module commit_arbiter #(
  parameter int NUM_UNITS  = 5,
  parameter int NUM_WPORTS = 1,
  parameter int DATA_W     = 64,
  parameter int RN_W       = 6,
  parameter int QDEPTH     = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic [NUM_UNITS-1:0]                   u_valid,
  input  logic [NUM_UNITS*RN_W-1:0]              u_rn,
  input  logic [NUM_UNITS*DATA_W-1:0]            u_data,
  output logic [NUM_UNITS-1:0]                   u_stall,
  output logic [NUM_WPORTS-1:0]                  w_en,
  output logic [NUM_WPORTS*RN_W-1:0]             w_rn,
  output logic [NUM_WPORTS*DATA_W-1:0]           w_data,
  output logic [NUM_WPORTS-1:0]                  free_en,
  output logic [NUM_WPORTS*RN_W-1:0]             free_rn,
  output logic [NUM_UNITS*($clog2(QDEPTH)+1)-1:0] occupancy
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int PW = $clog2(QDEPTH);
  localparam int UW = $clog2(NUM_UNITS);

  logic [CW-1:0]     cnt    [NUM_UNITS];
  logic [PW-1:0]     rd_ptr [NUM_UNITS];
  logic [PW-1:0]     wr_ptr [NUM_UNITS];
  logic [RN_W-1:0]   q_rn   [NUM_UNITS][QDEPTH];
  logic [DATA_W-1:0] q_data [NUM_UNITS][QDEPTH];
  logic [UW-1:0]     rr;
  logic [UW-1:0]     rr_next;

  logic [RN_W-1:0]   u_rn_a   [NUM_UNITS];
  logic [DATA_W-1:0] u_data_a [NUM_UNITS];
  logic [NUM_UNITS-1:0] has_rn, cand, pop, push, bypass;

  logic [NUM_WPORTS-1:0] gv;
  logic [RN_W-1:0]       g_rn   [NUM_WPORTS];
  logic [DATA_W-1:0]     g_data [NUM_WPORTS];

  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      u_rn_a[i]             = u_rn[i*RN_W +: RN_W];
      u_data_a[i]           = u_data[i*DATA_W +: DATA_W];
      has_rn[i]             = (u_rn[i*RN_W +: RN_W] != '0);
      u_stall[i]            = (cnt[i] == CW'(QDEPTH));
      occupancy[i*CW +: CW] = cnt[i];
`ifdef COMMIT_BYPASS_EN
      cand[i] = !flush && ((cnt[i] != '0) || (u_valid[i] && has_rn[i]));
`else
      cand[i] = !flush && (cnt[i] != '0);
`endif
    end
  end

  // Round-robin search from rr; the k-th hit goes to port k.
  always_comb begin
    int hits;
    int idx;
    logic [UW-1:0] ui;
    pop     = '0;
    bypass  = '0;
    gv      = '0;
    rr_next = rr;
    hits    = 0;
    idx     = 0;
    ui      = '0;
    for (int p = 0; p < NUM_WPORTS; p++) begin
      g_rn[p]   = '0;
      g_data[p] = '0;
    end
    for (int k = 0; k < NUM_UNITS; k++) begin
      idx = int'(rr) + k;
      if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
      ui = UW'(idx);
      if (cand[ui] && hits < NUM_WPORTS) begin
        for (int p = 0; p < NUM_WPORTS; p++) begin
          if (hits == p) begin
            gv[p] = 1'b1;
            if (cnt[ui] != '0) begin
              g_rn[p]   = q_rn[ui][rd_ptr[ui]];
              g_data[p] = q_data[ui][rd_ptr[ui]];
              pop[ui]   = 1'b1;
            end else begin
              g_rn[p]    = u_rn_a[ui];
              g_data[p]  = u_data_a[ui];
              bypass[ui] = 1'b1;
            end
          end
        end
        hits    = hits + 1;
        rr_next = (ui == UW'(NUM_UNITS - 1)) ? '0 : ui + 1'b1;
      end
    end
  end

  // r0 results are accepted but never stored; bypassed results skip the queue.
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++)
      push[i] = u_valid[i] && !u_stall[i] && has_rn[i] && !flush && !bypass[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        cnt[i]    <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        cnt[i]    <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
      end
      if (|gv) rr <= rr_next;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (push[i]) begin
        q_rn[i][wr_ptr[i]]   <= u_rn_a[i];
        q_data[i][wr_ptr[i]] <= u_data_a[i];
      end
    end
  end

  // Output register stage: idle ports drop w_en and w_rn but keep their last data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_en   <= '0;
      w_rn   <= '0;
      w_data <= '0;
    end else begin
      for (int p = 0; p < NUM_WPORTS; p++) begin
        w_en[p]               <= gv[p];
        w_rn[p*RN_W +: RN_W]  <= gv[p] ? g_rn[p] : '0;
        if (gv[p]) w_data[p*DATA_W +: DATA_W] <= g_data[p];
      end
    end
  end

  assign free_en = w_en;
  assign free_rn = w_rn;

  generate
    if (NUM_WPORTS == 2) begin : g_waw
      a_no_same_rn : assert property (@(posedge clk) disable iff (rst)
        (w_en[0] && w_en[1]) |-> (w_rn[0 +: RN_W] != w_rn[RN_W +: RN_W]));
    end
  endgenerate

endmodule
